// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_muldiv_unit                                            |
// | Description : Iterative multiply/divide unit owning the HI/LO register   |
// |               pair. mult/multu/div/divu complete in WIDTH+1 cycles using |
// |               a shift-add / restoring shift-subtract datapath on operand |
// |               magnitudes, followed by one sign-fix cycle. mthi/mtlo      |
// |               write HI/LO in a single cycle.                             |
// | Ports       : clk, rst_n (sync, active low)                              |
// |               start, op[2:0], busA, busB, flush  (request side)          |
// |               busy, done, div_by_zero            (handshake/status)      |
// |               hi, lo                             (HI/LO registers)       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] C_OP_MULT  = 3'd1;
  localparam logic [2:0] C_OP_MULTU = 3'd2;
  localparam logic [2:0] C_OP_DIV   = 3'd3;
  localparam logic [2:0] C_OP_DIVU  = 3'd4;
  localparam logic [2:0] C_OP_MTHI  = 3'd5;
  localparam logic [2:0] C_OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Working register: upper W+1 bits are the partial product / partial
  // remainder, lower W bits the multiplier / dividend-quotient shift field.
  logic [2*WIDTH:0]   pr_q, pr_d;
  logic [WIDTH-1:0]   m_q, m_d;          // |multiplicand| or |divisor|
  logic               neg_q, neg_d;      // product / quotient must be negated
  logic               rneg_q, rneg_d;    // remainder must be negated
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand magnitudes and signs at accept time
  logic               op_signed;
  logic               op_is_div;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign op_signed = (op == C_OP_MULT) || (op == C_OP_DIV);
  assign op_is_div = (op == C_OP_DIV)  || (op == C_OP_DIVU);
  assign sign_a    = op_signed & busA[WIDTH-1];
  assign sign_b    = op_signed & busB[WIDTH-1];
  // |-2^(W-1)| is 2^(W-1), which still fits as an unsigned W-bit magnitude.
  assign abs_a     = sign_a ? (~busA + 1'b1) : busA;
  assign abs_b     = sign_b ? (~busB + 1'b1) : busB;

  // Shift-add step: conditionally add multiplicand into the upper half,
  // then shift the whole register right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   pr_mul_next;
  assign mul_sum     = pr_q[2*WIDTH:WIDTH] + (pr_q[0] ? {1'b0, m_q} : '0);
  assign pr_mul_next = {1'b0, mul_sum, pr_q[WIDTH-1:1]};

  // Restoring divide step: shift left, trial-subtract divisor from the
  // partial remainder, keep the difference and set the quotient bit on success.
  logic [2*WIDTH:0]   div_shl;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH:0]   pr_div_next;
  assign div_shl     = {pr_q[2*WIDTH-1:0], 1'b0};
  assign div_ge      = div_shl[2*WIDTH:WIDTH] >= {1'b0, m_q};
  assign div_diff    = div_shl[2*WIDTH:WIDTH] - {1'b0, m_q};
  assign pr_div_next = div_ge ? {div_diff, div_shl[WIDTH-1:1], 1'b1} : div_shl;

  // Sign-corrected results available in FIX
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_mag = pr_q[2*WIDTH-1:0];
  assign prod_fix = neg_q  ? (~prod_mag + 1'b1) : prod_mag;
  assign quo_fix  = neg_q  ? (~pr_q[WIDTH-1:0] + 1'b1) : pr_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? (~pr_q[2*WIDTH-1:WIDTH] + 1'b1) : pr_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pr_d     = pr_q;
    m_d      = m_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      ST_IDLE: begin
        // flush alongside start suppresses the request
        if (start && !flush) begin
          case (op)
            C_OP_MULT, C_OP_MULTU, C_OP_DIV, C_OP_DIVU: begin
              if (op_is_div && (busB == '0)) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                dbz_d    = 1'b0;
                state_d  = ST_RUN;
                cnt_d    = '0;
                pr_d     = {{(WIDTH+1){1'b0}}, abs_a};
                m_d      = abs_b;
                neg_d    = sign_a ^ sign_b;
                rneg_d   = sign_a;
                is_div_d = op_is_div;
              end
            end
            C_OP_MTHI: begin
              hi_d   = busA;
              done_d = 1'b1;
              dbz_d  = 1'b0;
            end
            C_OP_MTLO: begin
              lo_d   = busA;
              done_d = 1'b1;
              dbz_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          pr_d  = is_div_q ? pr_div_next : pr_mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST_ITER) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        // flush wins over the commit on the same edge
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pr_q     <= '0;
      m_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pr_q     <= pr_d;
      m_q      <= m_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_muldiv_unit                                         |
// | Description : Directed self-checking bench for alu_muldiv_unit           |
// |               (WIDTH=32) with hand-computed expected values.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_alu_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;

  alu_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .busA        (busA),
    .busB        (busB),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle request; returns just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    busA  = a;
    busB  = b;
    step();
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Wait for done; reports edges after the accept edge. Scrambles operands
  // so that a design re-reading busA/busB during RUN gets caught.
  task automatic wait_done(input string tag, output int edges);
    bit got;
    got   = 1'b0;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      busA = 32'hA5A5_5A5A ^ i;
      busB = 32'h1234_5678 + i;
      step();
      if (done) begin
        edges = i;
        got   = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  int n;
  int done_cnt;
  int done_edge;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    busA  = '0;
    busB  = '0;
    flush = 1'b0;
    step();
    step();
    check("reset_status", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    step();

    // mult -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done("mult", n);
    check("mult_latency", 64'(n), 64'd33);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    step();
    check("mult_done_pulse", {63'd0, done}, 64'd0);

    // multu same operands
    issue(3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done("multu", n);
    check("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_neg", n);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_neg_dbz", {63'd0, div_by_zero}, 64'd0);

    // divu 0xFFFFFFF9 / 2
    issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("divu", n);
    check("divu_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);

    // mthi/mtlo preload, then divide by zero
    issue(3'd5, 32'h0000_0011, 32'h0);
    check("mthi_done", {62'd0, done, busy}, 64'd2);
    check("mthi_hi", {32'd0, hi}, 64'h11);
    step();
    issue(3'd6, 32'h0000_0022, 32'h0);
    check("mtlo_done", {62'd0, done, busy}, 64'd2);
    check("mtlo_lo", {32'd0, lo}, 64'h22);
    step();
    issue(3'd3, 32'h0000_0064, 32'h0);
    check("dbz_status", {61'd0, busy, done, div_by_zero}, 64'b011);
    check("dbz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    step();
    check("dbz_hold", {61'd0, busy, done, div_by_zero}, 64'b001);

    // div most-negative / -1, with an extra start pulsed mid-RUN
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_dbz_cleared", {63'd0, div_by_zero}, 64'd0);
    done_cnt  = 0;
    done_edge = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 6) begin
        start = 1'b1;
        op    = 3'd1;
        busA  = 32'd3;
        busB  = 32'd3;
      end else begin
        start = 1'b0;
        op    = 3'd0;
      end
      step();
      if (done) begin
        done_cnt++;
        done_edge = i;
      end
    end
    check("ovf_one_done", 64'(done_cnt), 64'd1);
    check("ovf_latency", 64'(done_edge), 64'd33);
    check("ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check("ovf_idle_after", {63'd0, busy}, 64'd0);

    // flush at RUN cycle 10 of a mult
    issue(3'd1, 32'd100, 32'd200);
    for (int i = 1; i < 10; i++) step();
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("flush_no_done", 64'(done_cnt), 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h0000_0000_8000_0000);

    // flush together with start in IDLE: request ignored
    start = 1'b1;
    op    = 3'd5;
    busA  = 32'hDEAD_BEEF;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    check("idle_flush_start", {62'd0, done, busy}, 64'd0);
    check("idle_flush_hi", {32'd0, hi}, 64'd0);

    // reset mid-RUN
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    check("rst_mid_status", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    step();

    // back-to-back: mtlo 5, then mult 6*7 the cycle after its done
    issue(3'd6, 32'd5, 32'd0);
    check("b2b_mtlo_done", {63'd0, done}, 64'd1);
    check("b2b_mtlo_lo", {hi, lo}, 64'h0000_0000_0000_0005);
    step();
    issue(3'd1, 32'd6, 32'd7);
    wait_done("b2b_mult", n);
    check("b2b_mult_latency", 64'(n), 64'd33);
    check("b2b_mult_hilo", {hi, lo}, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
